issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/offnariscv_pkg.sv | 13 +
 rtl/issue_scoreboard_if.sv | 32 +++
 rtl/issue_scoreboard.sv | 96 +++++++++
 tb/tb_issue_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/offnariscv_pkg.sv
// Shared types and constants for the issue-stage scoreboard.
// Holds the scoreboard FSM encoding and the default in-flight limit.
package offnariscv_pkg;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_t;

    localparam int SB_MAX_INFLIGHT = 4;
    localparam int SB_NUM_REGS     = 32;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Dispatch / writeback / status bundle between the issue stage and the scoreboard.
// master = pipeline side driving requests, slave = scoreboard.
interface issue_scoreboard_if;

    logic        disp_valid;
    logic [4:0]  disp_rd;
    logic [4:0]  disp_rs1;
    logic [4:0]  disp_rs2;
    logic        disp_rs1_use;
    logic        disp_rs2_use;
    logic        disp_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy;
    logic [3:0]  inflight_cnt;
    logic        draining;
    logic        err;

    modport master (
        output disp_valid, disp_rd, disp_rs1, disp_rs2, disp_rs1_use, disp_rs2_use,
        output wb_valid, wb_rd, flush,
        input  disp_ready, busy, inflight_cnt, draining, err
    );

    modport slave (
        input  disp_valid, disp_rd, disp_rs1, disp_rs2, disp_rs1_use, disp_rs2_use,
        input  wb_valid, wb_rd, flush,
        output disp_ready, busy, inflight_cnt, draining, err
    );

endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: RAW/WAW hazard check, per-register busy mask, in-flight counter.
// disp_ready is combinational from registered state only; writebacks take effect at the next edge.
module issue_scoreboard
    import offnariscv_pkg::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave sb
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    sb_state_t   state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic disp_ready;
    logic disp_fire;
    logic raw_hazard;
    logic waw_hazard;
    logic wb_bad;
    logic wb_ok;

    // Hazard check looks only at registered busy bits, so a same-cycle writeback never bypasses.
    always_comb begin
        raw_hazard = (sb.disp_rs1_use && busy_q[sb.disp_rs1]) ||
                     (sb.disp_rs2_use && busy_q[sb.disp_rs2]);
        waw_hazard = busy_q[sb.disp_rd];
        disp_ready = (state_q == SB_RUN) && !sb.flush && (cnt_q < MAX_CNT) &&
                     !raw_hazard && !waw_hazard;
        disp_fire  = sb.disp_valid && disp_ready;
        wb_bad     = sb.wb_valid &&
                     ((cnt_q == 4'd0) || ((sb.wb_rd != 5'd0) && !busy_q[sb.wb_rd]));
        wb_ok      = sb.wb_valid && !wb_bad;
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q | wb_bad;
        if (wb_ok) begin
            busy_d[sb.wb_rd] = 1'b0;
        end
        if (disp_fire) begin
            busy_d[sb.disp_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        case ({disp_fire, wb_ok})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // DRAIN exits on the registered count, so an empty flush still costs one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_RUN: begin
                if (sb.flush) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                if (!sb.flush && (cnt_q == 4'd0)) begin
                    state_d = SB_RUN;
                end
            end
            default: state_d = SB_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SB_RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign sb.disp_ready   = disp_ready;
    assign sb.busy         = busy_q;
    assign sb.inflight_cnt = cnt_q;
    assign sb.draining     = (state_q == SB_DRAIN);
    assign sb.err          = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed plus randomized bench for issue_scoreboard against a register-set / counter model.
module tb_issue_scoreboard;

    localparam int MAXI = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
        .clk (clk),
        .rst (rst_n),
        .sb  (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of registers awaiting writeback, count of in-flight ops, flags.
    bit m_busy [32];
    int m_cnt;
    bit m_drain;
    bit m_err;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_cnt   = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_ready(bit fl, int rd, int rs1, bit u1, int rs2, bit u2);
        return !m_drain && !fl && (m_cnt < MAXI) && !m_busy[rd] &&
               !(u1 && m_busy[rs1]) && !(u2 && m_busy[rs2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the falling edge, compare, advance model, next falling edge.
    task automatic cyc(input bit dv, input int rd, input int rs1, input bit u1, input int rs2,
                       input bit u2, input bit wv, input int wrd, input bit fl, output bit rdy);
        bit exp_rdy;
        bit acc;
        int cnt0;
        bit dr0;
        sb_if.disp_valid   = dv;
        sb_if.disp_rd      = 5'(rd);
        sb_if.disp_rs1     = 5'(rs1);
        sb_if.disp_rs1_use = u1;
        sb_if.disp_rs2     = 5'(rs2);
        sb_if.disp_rs2_use = u2;
        sb_if.wb_valid     = wv;
        sb_if.wb_rd        = 5'(wrd);
        sb_if.flush        = fl;
        #1;
        exp_rdy = m_ready(fl, rd, rs1, u1, rs2, u2);
        rdy     = sb_if.disp_ready;
        chk("ready",    32'(sb_if.disp_ready),   32'(exp_rdy));
        chk("busy",     sb_if.busy,              m_busy_vec());
        chk("cnt",      32'(sb_if.inflight_cnt), 32'(m_cnt));
        chk("draining", 32'(sb_if.draining),     32'(m_drain));
        chk("err",      32'(sb_if.err),          32'(m_err));
        acc  = dv && exp_rdy;
        cnt0 = m_cnt;
        dr0  = m_drain;
        if (wv) begin
            if (m_cnt == 0 || (wrd != 0 && !m_busy[wrd])) begin
                m_err = 1'b1;
            end else begin
                m_cnt--;
                m_busy[wrd] = 1'b0;
            end
        end
        if (acc) begin
            m_cnt++;
            if (rd != 0) m_busy[rd] = 1'b1;
        end
        if (fl) m_drain = 1'b1;
        else if (dr0 && cnt0 == 0) m_drain = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit wv, input int wrd);
        bit r;
        cyc(0, 0, 0, 0, 0, 0, wv, wrd, 0, r);
    endtask

    function automatic int pick_wb();
        int bl[$];
        for (int i = 1; i < 32; i++) if (m_busy[i]) bl.push_back(i);
        if (bl.size() == 0) return 0;
        return bl[$urandom_range(0, bl.size() - 1)];
    endfunction

    initial begin
        bit r;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sb_if.disp_valid = 0; sb_if.disp_rd = 0; sb_if.disp_rs1 = 0; sb_if.disp_rs2 = 0;
        sb_if.disp_rs1_use = 0; sb_if.disp_rs2_use = 0;
        sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush = 0;
        m_reset();
        #2;
        chk("rst_busy",  sb_if.busy, 32'h0);
        chk("rst_cnt",   32'(sb_if.inflight_cnt), 32'd0);
        chk("rst_drain", 32'(sb_if.draining), 32'd0);
        chk("rst_err",   32'(sb_if.err), 32'd0);
        chk("rst_ready", 32'(sb_if.disp_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // RAW on rd=5, cleared by writeback only one cycle later
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, r); chk("raw_first_acc", 32'(r), 32'd1);
        cyc(1, 6, 5, 1, 0, 0, 0, 0, 0, r); chk("raw_stall", 32'(r), 32'd0);
        cyc(1, 6, 5, 1, 0, 0, 1, 5, 0, r); chk("raw_no_bypass", 32'(r), 32'd0);
        cyc(1, 6, 5, 1, 0, 0, 0, 0, 0, r); chk("raw_release", 32'(r), 32'd1);
        idle(1, 6);

        // In-flight limit
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0, 0, 0, 0, 0, 0, r);
        chk("full_cnt", 32'(sb_if.inflight_cnt), 32'd4);
        cyc(1, 8, 0, 0, 0, 0, 0, 0, 0, r); chk("full_stall", 32'(r), 32'd0);
        cyc(1, 8, 0, 0, 0, 0, 1, 1, 0, r); chk("full_wb_same", 32'(r), 32'd0);
        chk("full_cnt3", 32'(sb_if.inflight_cnt), 32'd3);
        cyc(1, 8, 0, 0, 0, 0, 0, 0, 0, r); chk("full_release", 32'(r), 32'd1);
        idle(1, 2); idle(1, 3); idle(1, 4); idle(1, 8);

        // Simultaneous dispatch and writeback
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, r);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, r);
        cyc(1, 7, 0, 0, 0, 0, 1, 3, 0, r); chk("dwb_acc", 32'(r), 32'd1);
        chk("dwb_cnt", 32'(sb_if.inflight_cnt), 32'd2);
        chk("dwb_b7", 32'(sb_if.busy[7]), 32'd1);
        chk("dwb_b3", 32'(sb_if.busy[3]), 32'd0);
        idle(1, 9); idle(1, 7);

        // Flush with two in flight, writeback in the flush cycle
        cyc(1, 10, 0, 0, 0, 0, 0, 0, 0, r);
        cyc(1, 11, 0, 0, 0, 0, 0, 0, 0, r);
        cyc(1, 12, 0, 0, 0, 0, 1, 10, 1, r); chk("fl_disp_blocked", 32'(r), 32'd0);
        chk("fl_drain", 32'(sb_if.draining), 32'd1);
        chk("fl_wb_done", 32'(sb_if.inflight_cnt), 32'd1);
        cyc(1, 12, 0, 0, 0, 0, 1, 11, 0, r); chk("fl_drain_rdy", 32'(r), 32'd0);
        chk("fl_drain_cnt0", 32'(sb_if.draining), 32'd1);
        cyc(1, 12, 0, 0, 0, 0, 0, 0, 0, r); chk("fl_last_drain_rdy", 32'(r), 32'd0);
        chk("fl_run", 32'(sb_if.draining), 32'd0);
        cyc(1, 12, 0, 0, 0, 0, 0, 0, 0, r); chk("fl_run_rdy", 32'(r), 32'd1);
        idle(1, 12);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, r);
        chk("fl0_drain", 32'(sb_if.draining), 32'd1);
        idle(0, 0);
        chk("fl0_run", 32'(sb_if.draining), 32'd0);

        // Randomized legal traffic
        for (int n = 0; n < 400; n++) begin
            bit dv, u1, u2, wv, fl;
            int rd, rs1, rs2, wrd;
            dv  = 1'($urandom_range(0, 1));
            rd  = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            wv  = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            wrd = pick_wb();
            fl  = ($urandom_range(0, 24) == 0);
            cyc(dv, rd, rs1, u1, rs2, u2, wv, wrd, fl, r);
        end
        for (int n = 0; n < 64 && m_cnt > 0; n++) idle(1, pick_wb());
        for (int n = 0; n < 3; n++) idle(0, 0);

        // Writeback of a register that is not pending
        cyc(1, 13, 0, 0, 0, 0, 0, 0, 0, r);
        idle(1, 14);
        chk("badwb_err", 32'(sb_if.err), 32'd1);
        chk("badwb_cnt", 32'(sb_if.inflight_cnt), 32'd1);
        chk("badwb_b13", 32'(sb_if.busy[13]), 32'd1);
        idle(1, 13);

        // Async reset with busy=0xF0, cnt=3
        for (int i = 4; i <= 7; i++) cyc(1, i, 0, 0, 0, 0, 0, 0, 0, r);
        idle(1, 0);
        chk("pre_rst_busy", sb_if.busy, 32'h0000_00F0);
        chk("pre_rst_cnt", 32'(sb_if.inflight_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", sb_if.busy, 32'h0);
        chk("arst_cnt", 32'(sb_if.inflight_cnt), 32'd0);
        chk("arst_err", 32'(sb_if.err), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Writeback with nothing in flight sets a sticky error
        idle(1, 0);
        chk("underflow_err", 32'(sb_if.err), 32'd1);
        chk("underflow_cnt", 32'(sb_if.inflight_cnt), 32'd0);
        cyc(1, 20, 0, 0, 0, 0, 0, 0, 0, r);
        idle(1, 20);
        idle(0, 0);
        chk("err_sticky", 32'(sb_if.err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
